// File: rtl/matmul_arbiter.sv
// Round-robin arbiter granting one requester at a time exclusive use of a shared
// matmul_array. It issues a single start pulse, waits for completion under a watchdog,
// and returns a one-cycle done pulse to the owner.
module matmul_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDX_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] req_done,
  output logic               mm_start,
  input  logic               mm_done,
  output logic               busy,
  output logic               timeout_err,
  input  logic               clr_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               set_tmo;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int unsigned        cand;

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic for the FSM, grant registers, pointer and watchdog.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    set_tmo       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          grant_valid_d    = 1'b1;
          state_d          = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (mm_done) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          set_tmo = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        rr_ptr_d      = (32'(grant_idx_q) + 32'd1 >= NUM_REQ) ? '0 : grant_idx_q + 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky watchdog flag; a timeout in the same cycle as a clear keeps the flag set.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (clr_err) timeout_err_d = 1'b0;
    if (set_tmo) timeout_err_d = 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs decoded purely from registered state and grant.
  always_comb begin
    grant       = grant_q;
    grant_idx   = grant_idx_q;
    grant_valid = grant_valid_q;
    mm_start    = (state_q == S_START);
    busy        = (state_q != S_IDLE);
    req_done    = (state_q == S_RESP) ? grant_q : '0;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Self-checking bench for matmul_arbiter: directed scenarios plus randomized operations,
// checked against a transaction-level round-robin model.
module tb_matmul_arbiter;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic [3:0] req_done;
  logic       mm_start;
  logic       mm_done;
  logic       busy;
  logic       timeout_err;
  logic       clr_err;

  int total = 0;
  int bad   = 0;

  // Model state: pending request vector, round-robin pointer, expected error flag.
  logic [3:0] pend;
  int         ptr;
  logic       terr_exp;
  int         o;

  matmul_arbiter #(
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(TMO),
    .IDX_W         (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .req_done   (req_done),
    .mm_start   (mm_start),
    .mm_done    (mm_done),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner is the first pending requester at or above the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    int c;
    for (int i = 0; i < 4; i++) begin
      c = (p + i) % 4;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_idx"}, 32'(grant_idx), 32'd0);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_done"}, 32'(req_done), 32'd0);
    chk({tag, "_start"}, 32'(mm_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1 chk_all_zero("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    ptr = 0; pend = '0; req = '0; mm_done = 1'b0; clr_err = 1'b0; terr_exp = 1'b0;
  endtask

  // One full operation starting in idle. d < 0 means mm_done never comes (timeout).
  task automatic run_op(input int d, input bit spur, input bit drop, input bit keep,
                        input logic [3:0] add_bits, input bit clr_at_set, output int obs_idx);
    int         own;
    logic [3:0] oh;
    own = rr_pick(pend, ptr);
    oh  = 4'b0001 << own;
    req = pend;
    tick();
    obs_idx = 32'(grant_idx);
    chk("grant", 32'(grant), 32'(oh));
    chk("grant_idx", 32'(grant_idx), 32'(own));
    chk("grant_valid", 32'(grant_valid), 32'd1);
    chk("mm_start", 32'(mm_start), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    mm_done = spur;
    pend = pend | add_bits;
    req  = pend;
    tick();
    chk("start_once", 32'(mm_start), 32'd0);
    chk("hold_w0", 32'(grant), 32'(oh));
    chk("no_early_done", 32'(req_done), 32'd0);
    mm_done = 1'b0;
    if (drop) begin
      pend[own[1:0]] = 1'b0;
      req = pend;
    end
    if (d < 0) begin
      for (int i = 1; i < TMO; i++) begin
        tick();
        chk("tmo_wait_done", 32'(req_done), 32'd0);
        chk("tmo_wait_err", 32'(timeout_err), 32'(terr_exp));
        chk("tmo_hold", 32'(grant), 32'(oh));
      end
      clr_err = clr_at_set;
      tick();
      terr_exp = 1'b1;
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      chk("tmo_req_done", 32'(req_done), 32'(oh));
    end else begin
      for (int i = 0; i < d; i++) begin
        tick();
        chk("wait_done", 32'(req_done), 32'd0);
        chk("wait_hold", 32'(grant), 32'(oh));
        chk("wait_start", 32'(mm_start), 32'd0);
      end
      mm_done = 1'b1;
      tick();
      chk("req_done", 32'(req_done), 32'(oh));
      chk("resp_hold", 32'(grant), 32'(oh));
      chk("resp_valid", 32'(grant_valid), 32'd1);
      chk("resp_err", 32'(timeout_err), 32'(terr_exp));
    end
    mm_done = 1'b0;
    clr_err = 1'b0;
    ptr = (own + 1) % 4;
    if (keep) pend[own[1:0]] = 1'b1;
    else      pend[own[1:0]] = 1'b0;
    req = pend;
    tick();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_valid", 32'(grant_valid), 32'd0);
    chk("post_grant", 32'(grant), 32'd0);
    chk("post_done", 32'(req_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; mm_done = 1'b0; clr_err = 1'b0;
    pend = '0; ptr = 0; terr_exp = 1'b0;
    do_reset();

    // Owner 0 withdraws during wait; grant held, then requester 1 follows.
    pend = 4'b0011;
    run_op(5, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, o);
    run_op(2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);

    // Single request from slot 2.
    pend = 4'b0100;
    run_op(9, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);

    // Spurious mm_done in idle, then in the start cycle.
    req = '0; mm_done = 1'b1;
    tick();
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_done", 32'(req_done), 32'd0);
    chk("spur_idle_valid", 32'(grant_valid), 32'd0);
    mm_done = 1'b0;
    pend = 4'b1000;
    run_op(4, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, o);

    // Completion on the very last watchdog cycle is not a timeout.
    pend = 4'b0001;
    run_op(TMO - 1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);

    // Timeout, sticky flag, then clear.
    pend = 4'b0010;
    run_op(-1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);
    tick();
    chk("terr_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    terr_exp = 1'b0;
    chk("terr_clr", 32'(timeout_err), 32'd0);

    // Clear coinciding with a timeout: the set wins.
    pend = 4'b0100;
    run_op(-1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, o);
    chk("terr_set_wins", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    terr_exp = 1'b0;
    chk("terr_clr2", 32'(timeout_err), 32'd0);

    // Fairness: all requesting continuously from a fresh pointer.
    do_reset();
    pend = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_op(3, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, o);
      chk("rr_seq", 32'(o), 32'(i % 4));
    end
    pend = '0; req = '0;

    // Randomized operations.
    for (int n = 0; n < 20; n++) begin
      if (pend == 4'b0000) pend = 4'($urandom_range(1, 15));
      run_op(int'($urandom_range(0, TMO - 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'b0, o);
    end
    pend = '0; req = '0;
    tick();

    // Reset in the middle of a wait aborts silently; arbitration restarts from slot 0.
    pend = 4'b0001; req = pend;
    tick();
    chk("mid_grant", 32'(grant), 32'h1);
    repeat (5) tick();
    do_reset();
    pend = 4'b1010;
    run_op(2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);
    chk("post_rst_first", 32'(o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
